// File: rtl/intc_top.sv
// Four-source vectored interrupt controller with a memory-mapped ISR address table.
// IRQ, isr_addr and error are registered one cycle after the sampling edge; read_data is combinational.
// No backpressure: done is level-sampled and IACK retires the highest pending source.
module intc_top #(
  parameter logic [31:0] BASE_ADDR  = 32'h0002_0000,
  parameter logic [31:0] REG_STRIDE = 32'h20,
  parameter int          NUM_SRC    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SRC-1:0]  done,
  input  logic                IACK,
  input  logic [31:0]         input_addr,
  input  logic                write_enable,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data,
  output logic                IRQ,
  output logic [31:0]         isr_addr,
  output logic                error
);

  localparam logic [15:0] STRIDE     = REG_STRIDE[15:0];
  // STATUS sits directly after the last ISR register
  localparam logic [15:0] STATUS_OFF = STRIDE * 16'(NUM_SRC);

  logic [31:0]        isr_q [NUM_SRC];
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pending_next;
  logic [NUM_SRC-1:0] clear_mask;
  logic [1:0]         sel;
  logic [1:0]         sel_next;
  logic               win_hit;
  logic [15:0]        offset;
  logic               reg_hit;
  logic [1:0]         reg_idx;
  logic               status_hit;
  logic               bad_write;
  logic               error_next;

  // Highest set bit wins; returns 0 when nothing is set (callers gate on |vec)
  function automatic logic [1:0] highest(input logic [NUM_SRC-1:0] vec);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (vec[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  assign win_hit    = (input_addr[31:16] == BASE_ADDR[31:16]);
  assign offset     = input_addr[15:0];
  assign status_hit = win_hit && (offset == STATUS_OFF);

  // Decode which ISR register (if any) the bus address selects
  always_comb begin
    reg_hit = 1'b0;
    reg_idx = 2'd0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (win_hit && (offset == STRIDE * 16'(k))) begin
        reg_hit = 1'b1;
        reg_idx = 2'(k);
      end
    end
  end

  // Combinational register read; unmapped or out-of-window addresses read as zero
  always_comb begin
    read_data = 32'd0;
    if (reg_hit)
      read_data = isr_q[reg_idx];
    else if (status_hit)
      read_data = {{(32-NUM_SRC-1){1'b0}}, IRQ, pending};
  end

  // Retire/capture logic: an acknowledge only retires the current winner, a new done wins over it
  always_comb begin
    sel        = highest(pending);
    clear_mask = '0;
    if (IACK && IRQ)
      clear_mask[sel] = 1'b1;
    pending_next = (pending & ~clear_mask) | done;
    sel_next     = highest(pending_next);
    // writes inside the window that hit nothing writable (including STATUS) are flagged
    bad_write    = write_enable && win_hit && !reg_hit;
    error_next   = (IACK && !IRQ) || (|(done & pending & ~clear_mask)) || bad_write;
  end

  // ISR address table: bus writes land on the selected register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SRC; k++) isr_q[k] <= 32'd0;
    end else if (write_enable && reg_hit) begin
      isr_q[reg_idx] <= write_data;
    end
  end

  // Pending set, IRQ, vector and error pulse; the vector holds once nothing is pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      IRQ      <= 1'b0;
      isr_addr <= 32'd0;
      error    <= 1'b0;
    end else begin
      pending <= pending_next;
      IRQ     <= |pending_next;
      error   <= error_next;
      if (|pending_next)
        isr_addr <= isr_q[sel_next];
    end
  end

endmodule

// File: tb/tb_intc_top.sv
// Bench for intc_top: directed vector table, reset-while-active sequence, random run vs model.
// Inputs driven on the falling edge; outputs sampled 1ns after the rising edge.
// read_data is sampled combinationally before the edge that acts on the same inputs.
module tb_intc_top;

  logic        clk;
  logic        rst_n;
  logic [3:0]  done;
  logic        IACK;
  logic [31:0] input_addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        IRQ;
  logic [31:0] isr_addr;
  logic        error;

  int checks;
  int failures;

  intc_top dut (
    .clk(clk), .rst_n(rst_n), .done(done), .IACK(IACK),
    .input_addr(input_addr), .write_enable(write_enable), .write_data(write_data),
    .read_data(read_data), .IRQ(IRQ), .isr_addr(isr_addr), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  d;
    logic        ia;
    logic [31:0] a;
    logic        w;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
    logic [31:0] exp_isr;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  // ---------------- behavioural model ----------------
  logic [31:0] m_isr [4];
  logic [3:0]  m_pend;
  logic        m_irq;
  logic [31:0] m_isra;
  logic        m_err;

  function automatic int top_of(input logic [3:0] v);
    int t = -1;
    for (int i = 0; i < 4; i++) if (v[i]) t = i;
    return t;
  endfunction

  function automatic int reg_of(input logic [31:0] a);
    int off = int'(a[15:0]);
    if (a[31:16] != 16'h0002) return -1;
    if (off < 32'h80 && (off % 32'h20) == 0) return off / 32'h20;
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int r = reg_of(a);
    if (r >= 0) return m_isr[r];
    if (a == 32'h0002_0080) return 32'(m_pend) + (m_irq ? 32'h10 : 32'h0);
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_isr[i] = 32'd0;
    m_pend = 4'd0; m_irq = 1'b0; m_isra = 32'd0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] d, input logic ia, input logic [31:0] a,
                            input logic w, input logic [31:0] wd);
    logic [3:0] clr;
    logic [3:0] np;
    int r;
    clr = 4'd0;
    if (ia && m_irq && m_pend != 4'd0) clr = 4'(1 << top_of(m_pend));
    np = (m_pend & ~clr) | d;
    r = reg_of(a);
    m_err = (ia && !m_irq) || ((d & m_pend & ~clr) != 4'd0) ||
            (w && a[31:16] == 16'h0002 && r < 0);
    if (np != 4'd0) m_isra = m_isr[top_of(np)];
    if (w && r >= 0) m_isr[r] = wd;
    m_pend = np;
    m_irq  = (np != 4'd0);
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; returns read_data seen before the edge. Model steps in lockstep.
  task automatic cycle(input logic [3:0] d, input logic ia, input logic [31:0] a,
                       input logic w, input logic [31:0] wd, output logic [31:0] rd_pre);
    @(negedge clk);
    done = d; IACK = ia; input_addr = a; write_enable = w; write_data = wd;
    #1;
    rd_pre = read_data;
    model_step(d, ia, a, w, wd);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] d, input logic ia, input logic [31:0] a,
                              input logic w, input logic [31:0] wd, input logic [31:0] rd,
                              input logic irq, input logic [31:0] isr, input logic err);
    vec_t v;
    v.d = d; v.ia = ia; v.a = a; v.w = w; v.wd = wd;
    v.exp_rd = rd; v.exp_irq = irq; v.exp_isr = isr; v.exp_err = err;
    return v;
  endfunction

  localparam logic [31:0] R0 = 32'h0002_0000, R1 = 32'h0002_0020, R2 = 32'h0002_0040,
                          R3 = 32'h0002_0060, ST = 32'h0002_0080;

  logic [31:0] rd;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; done = 4'd0; IACK = 1'b0; input_addr = 32'd0;
    write_enable = 1'b0; write_data = 32'd0;
    model_reset();

    //            done  iack addr          we  wdata        rd_pre  irq isr        err
    tbl.push_back(mk(4'h0, 0, R0,           1, 32'hA,      32'h0,  0, 32'h0,    0));
    tbl.push_back(mk(4'h0, 0, R1,           1, 32'hB,      32'h0,  0, 32'h0,    0));
    tbl.push_back(mk(4'h0, 0, R2,           1, 32'hC,      32'h0,  0, 32'h0,    0));
    tbl.push_back(mk(4'h0, 0, R3,           1, 32'hD,      32'h0,  0, 32'h0,    0));
    tbl.push_back(mk(4'h0, 0, R0,           0, 32'h0,      32'hA,  0, 32'h0,    0));
    tbl.push_back(mk(4'h0, 0, R1,           0, 32'h0,      32'hB,  0, 32'h0,    0));
    tbl.push_back(mk(4'h0, 0, R2,           0, 32'h0,      32'hC,  0, 32'h0,    0));
    tbl.push_back(mk(4'h0, 0, R3,           0, 32'h0,      32'hD,  0, 32'h0,    0));
    tbl.push_back(mk(4'h8, 0, ST,           0, 32'h0,      32'h0,  1, 32'hD,    0));
    tbl.push_back(mk(4'h0, 0, ST,           0, 32'h0,      32'h18, 1, 32'hD,    0));
    tbl.push_back(mk(4'h0, 1, ST,           0, 32'h0,      32'h18, 0, 32'hD,    0));
    tbl.push_back(mk(4'h0, 0, ST,           0, 32'h0,      32'h0,  0, 32'hD,    0));
    tbl.push_back(mk(4'h4, 0, ST,           0, 32'h0,      32'h0,  1, 32'hC,    0));
    tbl.push_back(mk(4'h0, 1, ST,           0, 32'h0,      32'h14, 0, 32'hC,    0));
    tbl.push_back(mk(4'h1, 0, ST,           0, 32'h0,      32'h0,  1, 32'hA,    0));
    tbl.push_back(mk(4'h0, 1, ST,           0, 32'h0,      32'h11, 0, 32'hA,    0));
    tbl.push_back(mk(4'h2, 0, ST,           0, 32'h0,      32'h0,  1, 32'hB,    0));
    tbl.push_back(mk(4'h0, 1, ST,           0, 32'h0,      32'h12, 0, 32'hB,    0));
    tbl.push_back(mk(4'h5, 0, ST,           0, 32'h0,      32'h0,  1, 32'hC,    0));
    tbl.push_back(mk(4'h0, 1, ST,           0, 32'h0,      32'h15, 1, 32'hA,    0));
    tbl.push_back(mk(4'h0, 1, ST,           0, 32'h0,      32'h11, 0, 32'hA,    0));
    tbl.push_back(mk(4'h0, 1, ST,           0, 32'h0,      32'h0,  0, 32'hA,    1));
    tbl.push_back(mk(4'h0, 0, ST,           0, 32'h0,      32'h0,  0, 32'hA,    0));
    tbl.push_back(mk(4'h8, 0, ST,           0, 32'h0,      32'h0,  1, 32'hD,    0));
    tbl.push_back(mk(4'h8, 0, ST,           0, 32'h0,      32'h18, 1, 32'hD,    1));
    tbl.push_back(mk(4'h0, 1, ST,           0, 32'h0,      32'h18, 0, 32'hD,    0));
    tbl.push_back(mk(4'h0, 0, 32'h0003AAAA, 1, 32'hFFFF,   32'h0,  0, 32'hD,    0));
    tbl.push_back(mk(4'h0, 0, R0,           0, 32'h0,      32'hA,  0, 32'hD,    0));
    tbl.push_back(mk(4'h0, 0, ST,           1, 32'h1,      32'h0,  0, 32'hD,    1));
    tbl.push_back(mk(4'h0, 0, 32'h00020004, 1, 32'h77,     32'h0,  0, 32'hD,    1));
    tbl.push_back(mk(4'h0, 0, 32'h00020004, 0, 32'h0,      32'h0,  0, 32'hD,    0));
    tbl.push_back(mk(4'h4, 0, ST,           0, 32'h0,      32'h0,  1, 32'hC,    0));
    tbl.push_back(mk(4'h4, 1, ST,           0, 32'h0,      32'h14, 1, 32'hC,    0));
    tbl.push_back(mk(4'h0, 1, ST,           0, 32'h0,      32'h14, 0, 32'hC,    0));
    tbl.push_back(mk(4'h2, 0, ST,           0, 32'h0,      32'h0,  1, 32'hB,    0));
    tbl.push_back(mk(4'h0, 0, R1,           1, 32'h1234,   32'hB,  1, 32'hB,    0));
    tbl.push_back(mk(4'h0, 0, R1,           0, 32'h0,      32'h1234, 1, 32'h1234, 0));
    tbl.push_back(mk(4'h0, 1, R3,           0, 32'h0,      32'hD,  0, 32'h1234, 0));

    // reset state
    #12;
    check("reset_irq", {31'd0, IRQ}, 32'd0);
    check("reset_isr", isr_addr, 32'd0);
    check("reset_err", {31'd0, error}, 32'd0);
    input_addr = ST; #1;
    check("reset_status", read_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed table
    foreach (tbl[i]) begin
      cycle(tbl[i].d, tbl[i].ia, tbl[i].a, tbl[i].w, tbl[i].wd, rd);
      check($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'd0, IRQ}, {31'd0, tbl[i].exp_irq});
      check($sformatf("vec%0d_isr", i), isr_addr, tbl[i].exp_isr);
      check($sformatf("vec%0d_err", i), {31'd0, error}, {31'd0, tbl[i].exp_err});
    end

    // asynchronous reset while IRQ is high clears everything immediately
    cycle(4'h8, 1'b0, ST, 1'b0, 32'h0, rd);
    check("pre_rst_irq", {31'd0, IRQ}, 32'd1);
    @(negedge clk);
    done = 4'h0; input_addr = ST;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_irq", {31'd0, IRQ}, 32'd0);
    check("arst_isr", isr_addr, 32'd0);
    check("arst_status", read_data, 32'd0);
    input_addr = R0; #1;
    check("arst_reg0", read_data, 32'd0);
    input_addr = R3; #1;
    check("arst_reg3", read_data, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // randomized run against the model
    for (int n = 0; n < 400; n++) begin
      logic [3:0]  d;
      logic        ia;
      logic [31:0] a;
      logic        w;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      d  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      ia = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0: a = 32'h0002_0080;
        1: a = 32'h0002_0000 + 32'($urandom_range(0, 255));
        2: a = 32'h0003_0000 + 32'($urandom_range(0, 65535));
        default: a = 32'h0002_0000 + 32'h20 * 32'($urandom_range(0, 3));
      endcase
      w  = ($urandom_range(0, 3) == 0);
      wd = $urandom;
      exp_rd = model_read(a);
      cycle(d, ia, a, w, wd, rd);
      check($sformatf("rnd%0d_rd", n), rd, exp_rd);
      check($sformatf("rnd%0d_irq", n), {31'd0, IRQ}, {31'd0, m_irq});
      check($sformatf("rnd%0d_isr", n), isr_addr, m_isra);
      check($sformatf("rnd%0d_err", n), {31'd0, error}, {31'd0, m_err});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
